// File: rtl/oflow_cr_pkg.sv
// Shared widths, LUT entry layout and FSM state encoding for the oflow conflict resolver.
package oflow_cr_pkg;

  localparam int NUM_PE    = 8;
  localparam int MAX_ROWS  = 32;
  localparam int ID_W      = 11;
  localparam int SCORE_W   = 16;
  localparam int NUM_FB    = 4;
  localparam int MAX_ITER  = 4;

  localparam int PE_W      = $clog2(NUM_PE);
  localparam int ROW_W     = $clog2(MAX_ROWS);
  localparam int FB_W      = $clog2(NUM_FB + 1);
  localparam int IDX_W     = ROW_W + PE_W;
  localparam int ITER_W    = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
  localparam int LUT_DEPTH = 2 ** ID_W;

  typedef struct packed {
    logic               flag;
    logic [SCORE_W-1:0] score;
    logic [ROW_W-1:0]   row;
    logic [PE_W-1:0]    pe;
    logic [FB_W-1:0]    fb;
  } lut_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_SEL      = 3'd2,
    ST_CAP      = 3'd3,
    ST_CMP      = 3'd4,
    ST_NEXT     = 3'd5,
    ST_PASS_END = 3'd6,
    ST_DONE     = 3'd7
  } cr_state_e;

  // Next candidate index; NUM_FB means "dead" and is never exceeded.
  function automatic logic [FB_W-1:0] fb_next(input logic [FB_W-1:0] fb);
    if (fb >= FB_W'(NUM_FB - 1))
      return FB_W'(NUM_FB);
    else
      return fb + FB_W'(1);
  endfunction

endpackage

// File: rtl/oflow_cr_lut.sv
// Per-ID ownership LUT: flag flops (single-cycle clear) plus payload register array.
// One read and one write port, registered read data (1-cycle latency).
module oflow_cr_lut
  import oflow_cr_pkg::*;
(
  input  logic            clk,
  input  logic            reset_N,
  input  logic            clear,
  input  logic [ID_W-1:0] rd_id,
  output lut_entry_t      rd_entry,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_id,
  input  lut_entry_t      wr_entry
);

  localparam int PAYLOAD_W = $bits(lut_entry_t) - 1;

  logic [LUT_DEPTH-1:0] flag_q;
  logic [PAYLOAD_W-1:0] payload_q [LUT_DEPTH];
  logic                 rd_flag_q;
  logic [PAYLOAD_W-1:0] rd_payload_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      flag_q    <= '0;
      rd_flag_q <= 1'b0;
    end else begin
      if (clear)
        flag_q <= '0;
      else if (wr_en)
        flag_q[wr_id] <= wr_entry.flag;
      rd_flag_q <= flag_q[rd_id];
    end
  end

  // Payload is only meaningful behind a set flag, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      payload_q[wr_id] <= wr_entry[PAYLOAD_W-1:0];
    rd_payload_q <= payload_q[rd_id];
  end

  assign rd_entry = {rd_flag_q, rd_payload_q};

endmodule

// File: rtl/oflow_conflict_resolve_multi.sv
// Multi-pass conflict resolver: one owner per object ID, losers demoted to their next candidate.
// Optional statistics outputs (stat_conflicts, stat_passes) are built when CR_STATS_EN is defined.
//
//   state    | meaning
//   IDLE     | wait for start_cr
//   CLEAR    | clear LUT flags, zero entry index and demote flag
//   SEL      | drive score-board select for current entry
//   CAP      | capture score/id/fb, address LUT
//   CMP      | resolve ownership, update LUT, issue pointer write
//   NEXT     | advance entry index or end the pass
//   PASS_END | start another pass or finish
//   DONE     | pulse done_cr
module oflow_conflict_resolve_multi
  import oflow_cr_pkg::*;
(
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start_cr,
  input  logic [ROW_W:0]     num_rows,
  output logic               done_cr,
  output logic               busy_cr,
  output logic               iter_overflow,
  output logic [ROW_W-1:0]   row_sel_from_cr,
  output logic [PE_W-1:0]    pe_sel_from_cr,
  input  logic [SCORE_W-1:0] score_to_cr,
  input  logic [ID_W-1:0]    id_to_cr,
  input  logic [FB_W-1:0]    fb_idx_to_cr,
  output logic [ROW_W-1:0]   row_to_change,
  output logic [PE_W-1:0]    pe_to_change,
  output logic [FB_W-1:0]    data_to_score_board,
  output logic               write_to_pointer
`ifdef CR_STATS_EN
  ,
  output logic [15:0]        stat_conflicts,
  output logic [3:0]         stat_passes
`endif
);

  cr_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [ITER_W-1:0]  iter_q;
  logic               demote_q;
  logic [ROW_W:0]     rows_q;
  logic [SCORE_W-1:0] cap_score_q;
  logic [ID_W-1:0]    cap_id_q;
  logic [FB_W-1:0]    cap_fb_q;

  lut_entry_t         rd_entry, wr_entry;
  logic               dead, beats, lut_wr, last_entry;
  logic [IDX_W:0]     last_idx;

  // NUM_PE is a power of two, so the linear index is simply {row, pe}.
  assign last_idx   = {rows_q, {PE_W{1'b0}}} - (IDX_W + 1)'(1);
  assign last_entry = ({1'b0, idx_q} == last_idx);

  assign row_sel_from_cr = idx_q[IDX_W-1:PE_W];
  assign pe_sel_from_cr  = idx_q[PE_W-1:0];
  assign busy_cr         = (state_q != ST_IDLE);
  assign done_cr         = (state_q == ST_DONE);

  oflow_cr_lut u_lut (
    .clk      (clk),
    .reset_N  (reset_N),
    .clear    (state_q == ST_CLEAR),
    .rd_id    (id_to_cr),
    .rd_entry (rd_entry),
    .wr_en    (lut_wr),
    .wr_id    (cap_id_q),
    .wr_entry (wr_entry)
  );

  always_comb begin
    dead     = (cap_fb_q == FB_W'(NUM_FB));
    beats    = rd_entry.flag && (cap_score_q < rd_entry.score);
    lut_wr   = (state_q == ST_CMP) && !dead && (!rd_entry.flag || beats);
    wr_entry = '{flag: 1'b1, score: cap_score_q, row: idx_q[IDX_W-1:PE_W],
                 pe: idx_q[PE_W-1:0], fb: cap_fb_q};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_cr) state_d = ST_CLEAR;
      ST_CLEAR:    state_d = (rows_q == '0) ? ST_PASS_END : ST_SEL;
      ST_SEL:      state_d = ST_CAP;
      ST_CAP:      state_d = ST_CMP;
      ST_CMP:      state_d = ST_NEXT;
      ST_NEXT:     state_d = last_entry ? ST_PASS_END : ST_SEL;
      ST_PASS_END: state_d = (demote_q && iter_q != ITER_W'(MAX_ITER - 1)) ? ST_CLEAR : ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q             <= ST_IDLE;
      idx_q               <= '0;
      iter_q              <= '0;
      demote_q            <= 1'b0;
      rows_q              <= '0;
      cap_score_q         <= '0;
      cap_id_q            <= '0;
      cap_fb_q            <= '0;
      iter_overflow       <= 1'b0;
      row_to_change       <= '0;
      pe_to_change        <= '0;
      data_to_score_board <= '0;
      write_to_pointer    <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_to_pointer <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_cr) begin
          rows_q        <= num_rows;
          iter_q        <= '0;
          iter_overflow <= 1'b0;
        end
        ST_CLEAR: begin
          idx_q    <= '0;
          demote_q <= 1'b0;
        end
        ST_CAP: begin
          cap_score_q <= score_to_cr;
          cap_id_q    <= id_to_cr;
          cap_fb_q    <= fb_idx_to_cr;
        end
        ST_CMP: if (!dead && rd_entry.flag) begin
          write_to_pointer <= 1'b1;
          demote_q         <= 1'b1;
          if (beats) begin
            row_to_change       <= rd_entry.row;
            pe_to_change        <= rd_entry.pe;
            data_to_score_board <= fb_next(rd_entry.fb);
          end else begin
            row_to_change       <= idx_q[IDX_W-1:PE_W];
            pe_to_change        <= idx_q[PE_W-1:0];
            data_to_score_board <= fb_next(cap_fb_q);
          end
        end
        ST_NEXT: if (!last_entry) idx_q <= idx_q + IDX_W'(1);
        ST_PASS_END: begin
          if (state_d == ST_CLEAR)
            iter_q <= iter_q + ITER_W'(1);
          else
            iter_overflow <= demote_q;
        end
        default: ;
      endcase
    end
  end

`ifdef CR_STATS_EN
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      stat_conflicts <= '0;
      stat_passes    <= '0;
    end else if (state_q == ST_IDLE && start_cr) begin
      stat_conflicts <= '0;
      stat_passes    <= '0;
    end else begin
      if (state_q == ST_CLEAR)
        stat_passes <= stat_passes + 4'd1;
      if (write_to_pointer && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule
